// File: rtl/wb_arbiter.sv
// wb_arbiter: merges EXU and LSU results onto the single regfile write port
// and tracks pending register writes for RAW hazard stalls.
module wb_arbiter #(
    parameter int REGS_DIG = 4,
    parameter int XLEN     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exu_valid,
    output logic                       exu_ready,
    input  logic [REGS_DIG-1:0]        exu_rd,
    input  logic                       exu_wen,
    input  logic [XLEN-1:0]            exu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [REGS_DIG-1:0]        lsu_rd,
    input  logic [XLEN-1:0]            lsu_data,
    input  logic                       iss_valid,
    input  logic [REGS_DIG-1:0]        iss_rd,
    output logic [REGS_DIG-1:0]        rf_rd,
    output logic                       rf_wen,
    output logic [XLEN-1:0]            rf_wdata,
    output logic [(1<<REGS_DIG)-1:0]   busy
);
    localparam int NREG = 1 << REGS_DIG;

    logic [1:0]          starve_q, starve_d;
    logic [REGS_DIG-1:0] rf_rd_q, rf_rd_d;
    logic                rf_wen_q, rf_wen_d;
    logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]     busy_q, busy_d;
    logic                grant;
    logic [REGS_DIG-1:0] g_rd;
    logic                g_wen;

    // LSU wins contention unless EXU has already lost twice in a row
    assign exu_ready = exu_valid && (!lsu_valid || starve_q == 2'd2);
    assign lsu_ready = lsu_valid && !(exu_valid && starve_q == 2'd2);
    assign grant     = exu_ready || lsu_ready;
    assign g_rd      = exu_ready ? exu_rd : lsu_rd;
    assign g_wen     = exu_ready ? exu_wen : 1'b1;

    always_comb begin
        starve_d   = (exu_valid && !exu_ready) ? (starve_q == 2'd3 ? 2'd3 : starve_q + 2'd1) : 2'd0;
        rf_rd_d    = grant ? g_rd : rf_rd_q;
        rf_wdata_d = grant ? (exu_ready ? exu_data : lsu_data) : rf_wdata_q;
        rf_wen_d   = grant && g_wen && (g_rd != '0);
        busy_d     = '0;
        // a new issue to the same register outranks the retiring write
        for (int i = 1; i < NREG; i++)
            busy_d[i] = (iss_valid && iss_rd == REGS_DIG'(i)) ||
                        (busy_q[i] && !(rf_wen_d && rf_rd_d == REGS_DIG'(i)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= '0;
            rf_rd_q    <= '0;
            rf_wen_q   <= 1'b0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            starve_q   <= starve_d;
            rf_rd_q    <= rf_rd_d;
            rf_wen_q   <= rf_wen_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_rd    = rf_rd_q;
    assign rf_wen   = rf_wen_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a
// behavioural model of grants, the write port and the pending-write set.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready, exu_wen, lsu_valid, lsu_ready, iss_valid, rf_wen;
    logic [3:0]  exu_rd, lsu_rd, iss_rd, rf_rd;
    logic [31:0] exu_data, lsu_data, rf_wdata;
    logic [15:0] busy;

    int n_cmp = 0, n_err = 0;

    logic        m_ge, m_gl, m_wen, got_er, got_lr;
    logic [3:0]  m_rd;
    logic [31:0] m_wdata;
    logic [15:0] m_busy;
    int          m_wait;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd),
        .exu_wen(exu_wen), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
        .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rf_rd(rf_rd), .rf_wen(rf_wen), .rf_wdata(rf_wdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wen = 1'b0; m_rd = '0; m_wdata = '0; m_busy = '0; m_wait = 0;
    endtask

    task automatic idle();
        exu_valid = 0; exu_rd = 0; exu_wen = 0; exu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0; iss_valid = 0; iss_rd = 0;
    endtask

    // called at posedge+1; applies inputs, checks readies, steps one edge, checks outputs
    task automatic cycle(input logic ev, input logic [3:0] erd, input logic ew, input logic [31:0] ed,
                         input logic lv, input logic [3:0] lrd, input logic [31:0] ld,
                         input logic iv, input logic [3:0] ird);
        exu_valid = ev; exu_rd = erd; exu_wen = ew; exu_data = ed;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; iss_valid = iv; iss_rd = ird;
        #1;
        m_ge = ev && (!lv || m_wait >= 2);
        m_gl = lv && !m_ge;
        got_er = exu_ready; got_lr = lsu_ready;
        chk("exu_ready", exu_ready, m_ge);
        chk("lsu_ready", lsu_ready, m_gl);
        if (m_ge || m_gl) begin
            m_rd    = m_ge ? erd : lrd;
            m_wdata = m_ge ? ed : ld;
            m_wen   = (m_ge ? ew : 1'b1) && m_rd != 0;
        end else m_wen = 1'b0;
        m_wait = (ev && !m_ge) ? m_wait + 1 : 0;
        for (int i = 1; i < 16; i++) begin
            if (m_wen && m_rd == i) m_busy[i] = 1'b0;
            if (iv && ird == i) m_busy[i] = 1'b1;
        end
        @(posedge clk); #1;
        chk("rf_wen", rf_wen, m_wen);
        chk("rf_rd", rf_rd, m_rd);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("busy", busy, m_busy);
    endtask

    logic        pe, pe_w, pl;
    logic [3:0]  pe_rd, pl_rd;
    logic [31:0] pe_d, pl_d;

    initial begin
        idle(); model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        // single EXU result
        cycle(1, 5, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("t2_ready", got_er, 1);
        chk("t2_wen", rf_wen, 1);
        chk("t2_rd", rf_rd, 5);
        chk("t2_data", rf_wdata, 32'hDEADBEEF);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_wen_off", rf_wen, 0);
        // contention: L, L, E, L
        cycle(1, 4, 1, 32'h22, 1, 3, 32'h11, 0, 0);
        chk("t3_c1", {got_er, got_lr}, 2'b01);
        cycle(1, 4, 1, 32'h22, 1, 3, 32'h11, 0, 0);
        chk("t3_c2", {got_er, got_lr}, 2'b01);
        cycle(1, 4, 1, 32'h22, 1, 3, 32'h11, 0, 0);
        chk("t3_c3", {got_er, got_lr}, 2'b10);
        chk("t3_c3_data", rf_wdata, 32'h22);
        cycle(1, 4, 1, 32'h22, 1, 3, 32'h11, 0, 0);
        chk("t3_c4", {got_er, got_lr}, 2'b01);
        // x0 and wen=0 results complete without writing
        cycle(1, 0, 1, 32'h55, 0, 0, 0, 0, 0);
        chk("t4_x0_ready", got_er, 1);
        chk("t4_x0_wen", rf_wen, 0);
        chk("t4_x0_busy", busy, 0);
        cycle(1, 3, 0, 32'h66, 0, 0, 0, 0, 0);
        chk("t4_nowen", rf_wen, 0);
        cycle(0, 0, 0, 0, 1, 7, 32'h77, 0, 0);
        chk("t4_lsu_wen", rf_wen, 1);
        chk("t4_lsu_rd", rf_rd, 7);
        // scoreboard set-wins and clear
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 9);
        chk("t5_set", busy[9], 1);
        cycle(0, 0, 0, 0, 1, 9, 32'h99, 1, 9);
        chk("t5_setwins", busy[9], 1);
        cycle(0, 0, 0, 0, 1, 9, 32'h9A, 0, 0);
        chk("t5_clear", busy[9], 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t6_x0_iss", busy, 0);
        // asynchronous reset mid-cycle
        cycle(1, 5, 1, 32'h1, 0, 0, 0, 1, 1);
        cycle(1, 6, 1, 32'h2, 0, 0, 0, 1, 2);
        chk("t1_pre_busy", busy, 16'h0006);
        chk("t1_pre_wen", rf_wen, 1);
        idle();
        #2 rst = 1'b1;
        #1;
        chk("t1_async_wen", rf_wen, 0);
        chk("t1_async_rd", rf_rd, 0);
        chk("t1_async_data", rf_wdata, 0);
        chk("t1_async_busy", busy, 0);
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        cycle(1, 5, 1, 32'hABCD, 0, 0, 0, 0, 0);
        chk("t1_post_wen", rf_wen, 1);
        // randomized producers holding payload until accepted
        pe = 0; pl = 0; pe_w = 0; pe_rd = 0; pl_rd = 0; pe_d = 0; pl_d = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pe && $urandom_range(0, 2) != 0) begin
                pe = 1; pe_rd = 4'($urandom); pe_w = ($urandom_range(0, 4) != 0); pe_d = $urandom;
            end
            if (!pl && $urandom_range(0, 2) != 0) begin
                pl = 1; pl_rd = 4'($urandom); pl_d = $urandom;
            end
            cycle(pe, pe_rd, pe_w, pe_d, pl, pl_rd, pl_d, 1'($urandom), 4'($urandom));
            if (m_ge) pe = 0;
            if (m_gl) pl = 0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
